// File: rtl/e_mdu_if.sv
// Issue/result bundle between the E-stage issue logic and the multiply/divide unit.
// The issuer drives Start_E/MDUOp_E/A_E/B_E; the MDU returns Busy_E, HI/LO and MDUOut_E.
interface e_mdu_if;
  logic        Start_E;
  logic [3:0]  MDUOp_E;
  logic [31:0] A_E;
  logic [31:0] B_E;
  logic        Busy_E;
  logic [31:0] HI_E;
  logic [31:0] LO_E;
  logic [31:0] MDUOut_E;

  modport master (
    output Start_E, MDUOp_E, A_E, B_E,
    input  Busy_E, HI_E, LO_E, MDUOut_E
  );

  modport slave (
    input  Start_E, MDUOp_E, A_E, B_E,
    output Busy_E, HI_E, LO_E, MDUOut_E
  );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency MULT/DIV writing HI/LO, plus MTHI/MTLO/MFHI/MFLO.
// Define MDU_MADD_EN to enable MADD/MADDU (accumulate into {HI,LO}); otherwise ops 9/10 act as NONE.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic   clk,
  input logic   reset,
  e_mdu_if.slave mdu
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10
  } op_e;

  typedef enum logic {IDLE, BUSY} state_e;

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  op_e              op_q;
  logic [31:0]      a_q, b_q;
  logic [31:0]      hi_q, lo_q;

  logic             res_we_d;
  logic [31:0]      res_hi_d, res_lo_d;
  logic [63:0]      prod_s, prod_u;

  function automatic logic is_mult_class(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MADDU);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

  function automatic logic is_div_class(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  assign prod_s = $signed(a_q) * $signed(b_q);
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};

  // Result is formed only from latched operands; MADD reads the live {HI,LO} at completion.
  // NOTE: every always_comb output gets a default first so no latch is inferred on any path.
  always_comb begin
    res_we_d = 1'b1;
    res_hi_d = prod_s[63:32];
    res_lo_d = prod_s[31:0];
    case (op_q)
      OP_MULT:  {res_hi_d, res_lo_d} = prod_s;
      OP_MULTU: {res_hi_d, res_lo_d} = prod_u;
      OP_DIV: begin
        if (b_q == 32'd0) res_we_d = 1'b0;
        else begin
          res_lo_d = $signed(a_q) / $signed(b_q);
          res_hi_d = $signed(a_q) % $signed(b_q);
        end
      end
      OP_DIVU: begin
        if (b_q == 32'd0) res_we_d = 1'b0;
        else begin
          res_lo_d = a_q / b_q;
          res_hi_d = a_q % b_q;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {res_hi_d, res_lo_d} = {hi_q, lo_q} + prod_s;
      OP_MADDU: {res_hi_d, res_lo_d} = {hi_q, lo_q} + prod_u;
`endif
      default:  res_we_d = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      op_q    <= OP_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mdu.Start_E) begin
            if (is_mult_class(mdu.MDUOp_E) || is_div_class(mdu.MDUOp_E)) begin
              a_q     <= mdu.A_E;
              b_q     <= mdu.B_E;
              op_q    <= op_e'(mdu.MDUOp_E);
              cnt_q   <= is_div_class(mdu.MDUOp_E) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              busy_q  <= 1'b1;
              state_q <= BUSY;
            end else if (mdu.MDUOp_E == OP_MTHI) begin
              hi_q <= mdu.A_E;
            end else if (mdu.MDUOp_E == OP_MTLO) begin
              lo_q <= mdu.A_E;
            end
          end
        end
        BUSY: begin
          // Start_E is deliberately ignored here; the hazard unit should never issue while busy.
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
            if (res_we_d) begin
              hi_q <= res_hi_d;
              lo_q <= res_lo_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mdu.Busy_E   = busy_q;
  assign mdu.HI_E     = hi_q;
  assign mdu.LO_E     = lo_q;
  assign mdu.MDUOut_E = (mdu.MDUOp_E == OP_MFHI) ? hi_q :
                        (mdu.MDUOp_E == OP_MFLO) ? lo_q : 32'h0;

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu: multiply, divide, HI/LO moves, abort-by-reset, MADD option.
module tb_e_mdu;

  logic clk;
  logic reset;
  int   total_cnt;
  int   pass_cnt;

  e_mdu_if bus ();

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one Start_E cycle, then scrambles the operands to prove they were latched.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.Start_E = 1'b1;
    bus.MDUOp_E = op;
    bus.A_E     = a;
    bus.B_E     = b;
    @(negedge clk);
    bus.Start_E = 1'b0;
    bus.MDUOp_E = 4'd0;
    bus.A_E     = 32'hA5A5_5A5A;
    bus.B_E     = 32'h0F0F_F0F0;
  endtask

  // Counts negedges on which Busy_E is high, bounded so a stuck Busy_E cannot hang the run.
  task automatic busy_len(output int n);
    n = 0;
    while (bus.Busy_E === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    bus.Start_E = 1'b0;
    bus.MDUOp_E = 4'd7;
    bus.A_E     = '0;
    bus.B_E     = '0;
    reset       = 1'b0;
    #12;
    total_cnt++; if (bus.Busy_E !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.Busy_E); else pass_cnt++;
    total_cnt++; if (bus.HI_E !== 32'h0) $display("FAIL reset_hi got %h exp 0", bus.HI_E); else pass_cnt++;
    total_cnt++; if (bus.LO_E !== 32'h0) $display("FAIL reset_lo got %h exp 0", bus.LO_E); else pass_cnt++;
    total_cnt++; if (bus.MDUOut_E !== 32'h0) $display("FAIL reset_mfhi got %h exp 0", bus.MDUOut_E); else pass_cnt++;
    @(negedge clk);
    reset       = 1'b1;
    bus.MDUOp_E = 4'd0;
  endtask

  task automatic test_mfhi_mflo;
    issue(4'd5, 32'hDEAD_BEEF, 32'h0);
    total_cnt++; if (bus.Busy_E !== 1'b0) $display("FAIL mthi_busy got %b exp 0", bus.Busy_E); else pass_cnt++;
    issue(4'd6, 32'h0BAD_F00D, 32'h0);
    bus.MDUOp_E = 4'd7; #1;
    total_cnt++; if (bus.MDUOut_E !== 32'hDEAD_BEEF) $display("FAIL mfhi got %h exp deadbeef", bus.MDUOut_E); else pass_cnt++;
    bus.MDUOp_E = 4'd8; #1;
    total_cnt++; if (bus.MDUOut_E !== 32'h0BAD_F00D) $display("FAIL mflo got %h exp 0badf00d", bus.MDUOut_E); else pass_cnt++;
    bus.MDUOp_E = 4'd0; #1;
    total_cnt++; if (bus.MDUOut_E !== 32'h0) $display("FAIL mdu_none got %h exp 0", bus.MDUOut_E); else pass_cnt++;
    bus.MDUOp_E = 4'd5; #1;
    total_cnt++; if (bus.MDUOut_E !== 32'h0) $display("FAIL mdu_mthi_out got %h exp 0", bus.MDUOut_E); else pass_cnt++;
    bus.MDUOp_E = 4'd0;
  endtask

  task automatic test_mult;
    int n;
    issue(4'd1, 32'hFFFF_FFFF, 32'd2);
    bus.MDUOp_E = 4'd7; #1;
    total_cnt++; if (bus.MDUOut_E !== 32'hDEAD_BEEF) $display("FAIL mult_old_hi got %h exp deadbeef", bus.MDUOut_E); else pass_cnt++;
    bus.MDUOp_E = 4'd0;
    busy_len(n);
    total_cnt++; if (n !== 5) $display("FAIL mult_busy_cycles got %0d exp 5", n); else pass_cnt++;
    total_cnt++; if (bus.HI_E !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h exp ffffffff", bus.HI_E); else pass_cnt++;
    total_cnt++; if (bus.LO_E !== 32'hFFFF_FFFE) $display("FAIL mult_lo got %h exp fffffffe", bus.LO_E); else pass_cnt++;

    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    busy_len(n);
    total_cnt++; if (n !== 5) $display("FAIL multu_busy_cycles got %0d exp 5", n); else pass_cnt++;
    total_cnt++; if (bus.HI_E !== 32'h0000_0001) $display("FAIL multu_hi got %h exp 00000001", bus.HI_E); else pass_cnt++;
    total_cnt++; if (bus.LO_E !== 32'hFFFF_FFFE) $display("FAIL multu_lo got %h exp fffffffe", bus.LO_E); else pass_cnt++;
  endtask

  task automatic test_div;
    int n;
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    busy_len(n);
    total_cnt++; if (n !== 10) $display("FAIL div_busy_cycles got %0d exp 10", n); else pass_cnt++;
    total_cnt++; if (bus.LO_E !== 32'hFFFF_FFFD) $display("FAIL div_lo got %h exp fffffffd", bus.LO_E); else pass_cnt++;
    total_cnt++; if (bus.HI_E !== 32'hFFFF_FFFF) $display("FAIL div_hi got %h exp ffffffff", bus.HI_E); else pass_cnt++;

    issue(4'd3, 32'd7, 32'hFFFF_FFFE);
    busy_len(n);
    total_cnt++; if (bus.LO_E !== 32'hFFFF_FFFD) $display("FAIL div_negb_lo got %h exp fffffffd", bus.LO_E); else pass_cnt++;
    total_cnt++; if (bus.HI_E !== 32'h0000_0001) $display("FAIL div_negb_hi got %h exp 00000001", bus.HI_E); else pass_cnt++;

    issue(4'd4, 32'd7, 32'd2);
    busy_len(n);
    total_cnt++; if (n !== 10) $display("FAIL divu_busy_cycles got %0d exp 10", n); else pass_cnt++;
    total_cnt++; if (bus.LO_E !== 32'h3) $display("FAIL divu_lo got %h exp 3", bus.LO_E); else pass_cnt++;
    total_cnt++; if (bus.HI_E !== 32'h1) $display("FAIL divu_hi got %h exp 1", bus.HI_E); else pass_cnt++;
  endtask

  task automatic test_mthi_divzero;
    int n;
    issue(4'd5, 32'h0000_1234, 32'h0);
    total_cnt++; if (bus.HI_E !== 32'h1234) $display("FAIL mthi_hi got %h exp 1234", bus.HI_E); else pass_cnt++;
    total_cnt++; if (bus.Busy_E !== 1'b0) $display("FAIL mthi_busy2 got %b exp 0", bus.Busy_E); else pass_cnt++;
    issue(4'd4, 32'd5, 32'd0);
    busy_len(n);
    total_cnt++; if (n !== 10) $display("FAIL divz_busy_cycles got %0d exp 10", n); else pass_cnt++;
    total_cnt++; if (bus.HI_E !== 32'h1234) $display("FAIL divz_hi got %h exp 1234", bus.HI_E); else pass_cnt++;
    total_cnt++; if (bus.LO_E !== 32'h3) $display("FAIL divz_lo got %h exp 3", bus.LO_E); else pass_cnt++;
  endtask

  task automatic test_abort;
    issue(4'd6, 32'h0000_0055, 32'h0);
    issue(4'd1, 32'd3, 32'd5);
    @(negedge clk);
    bus.Start_E = 1'b1;
    bus.MDUOp_E = 4'd6;
    bus.A_E     = 32'h0000_00AA;
    @(negedge clk);
    bus.Start_E = 1'b0;
    bus.MDUOp_E = 4'd0;
    total_cnt++; if (bus.LO_E !== 32'h55) $display("FAIL busy_mtlo_ignored got %h exp 55", bus.LO_E); else pass_cnt++;
    total_cnt++; if (bus.Busy_E !== 1'b1) $display("FAIL abort_pre_busy got %b exp 1", bus.Busy_E); else pass_cnt++;
    reset = 1'b0; #1;
    total_cnt++; if (bus.Busy_E !== 1'b0) $display("FAIL abort_busy got %b exp 0", bus.Busy_E); else pass_cnt++;
    total_cnt++; if (bus.HI_E !== 32'h0) $display("FAIL abort_hi got %h exp 0", bus.HI_E); else pass_cnt++;
    total_cnt++; if (bus.LO_E !== 32'h0) $display("FAIL abort_lo got %h exp 0", bus.LO_E); else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    total_cnt++; if (bus.Busy_E !== 1'b0) $display("FAIL abort_late_busy got %b exp 0", bus.Busy_E); else pass_cnt++;
    total_cnt++; if ({bus.HI_E, bus.LO_E} !== 64'h0) $display("FAIL abort_late_hilo got %h exp 0", {bus.HI_E, bus.LO_E}); else pass_cnt++;
  endtask

  task automatic test_madd;
    int n;
`ifdef MDU_MADD_EN
    issue(4'd5, 32'h0, 32'h0);
    issue(4'd6, 32'hFFFF_FFFF, 32'h0);
    issue(4'd10, 32'd1, 32'd1);
    busy_len(n);
    total_cnt++; if (n !== 5) $display("FAIL maddu_busy_cycles got %0d exp 5", n); else pass_cnt++;
    total_cnt++; if (bus.HI_E !== 32'h1) $display("FAIL maddu_hi got %h exp 1", bus.HI_E); else pass_cnt++;
    total_cnt++; if (bus.LO_E !== 32'h0) $display("FAIL maddu_lo got %h exp 0", bus.LO_E); else pass_cnt++;
    issue(4'd9, 32'hFFFF_FFFF, 32'd1);
    busy_len(n);
    total_cnt++; if (bus.HI_E !== 32'h0) $display("FAIL madd_hi got %h exp 0", bus.HI_E); else pass_cnt++;
    total_cnt++; if (bus.LO_E !== 32'hFFFF_FFFF) $display("FAIL madd_lo got %h exp ffffffff", bus.LO_E); else pass_cnt++;
`else
    issue(4'd5, 32'h0000_0777, 32'h0);
    issue(4'd6, 32'h0000_0888, 32'h0);
    issue(4'd9, 32'd3, 32'd4);
    total_cnt++; if (bus.Busy_E !== 1'b0) $display("FAIL madd_off_busy got %b exp 0", bus.Busy_E); else pass_cnt++;
    issue(4'd10, 32'd3, 32'd4);
    total_cnt++; if (bus.Busy_E !== 1'b0) $display("FAIL maddu_off_busy got %b exp 0", bus.Busy_E); else pass_cnt++;
    busy_len(n);
    repeat (6) @(negedge clk);
    total_cnt++; if (bus.HI_E !== 32'h777) $display("FAIL madd_off_hi got %h exp 777", bus.HI_E); else pass_cnt++;
    total_cnt++; if (bus.LO_E !== 32'h888) $display("FAIL madd_off_lo got %h exp 888", bus.LO_E); else pass_cnt++;
`endif
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    test_reset();
    test_mfhi_mflo();
    test_mult();
    test_div();
    test_mthi_divzero();
    test_abort();
    test_madd();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
